conv3x3_gauss: RTL and testbench

Downstream consumer of the three-line buffer stage. Takes three vertically aligned pixel columns per in_valid, shifts them into a 3x3 window and applies a fixed Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16 with rounding. Produces one filtered pixel per window position inside the line. Pipelined and free-running, with no backpressure.

---
 rtl/conv_pkg.sv | 16 +
 rtl/row_sum121.sv | 21 ++
 rtl/conv3x3_gauss.sv | 148 ++++++++++++++
 tb/tb_conv3x3_gauss.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 Gaussian filter: kernel weights, rounding and
// the output-sum width helper.
package conv_pkg;

  localparam int unsigned K_EDGE = 1;
  localparam int unsigned K_SIDE = 2;
  localparam int unsigned K_CTR  = 4;
  localparam int unsigned KSHIFT = 4;
  localparam int unsigned ROUND  = 8;

  // Full 3x3 sum grows by log2(16) bits over the pixel width.
  function automatic int unsigned sum_width(input int unsigned data_width);
    return data_width + KSHIFT;
  endfunction

endpackage

// File: rtl/row_sum121.sv
// Combinational 1-2-1 weighted sum of three values; used per kernel row and
// again vertically across the three row sums.
module row_sum121
  import conv_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = IN_WIDTH + 2
) (
  input  logic [IN_WIDTH-1:0]  px_0,
  input  logic [IN_WIDTH-1:0]  px_1,
  input  logic [IN_WIDTH-1:0]  px_2,
  output logic [OUT_WIDTH-1:0] sum
);

  always_comb begin
    sum = OUT_WIDTH'(K_EDGE) * OUT_WIDTH'(px_0)
        + OUT_WIDTH'(K_SIDE) * OUT_WIDTH'(px_1)
        + OUT_WIDTH'(K_EDGE) * OUT_WIDTH'(px_2);
  end

endmodule

// File: rtl/conv3x3_gauss.sv
// 3x3 Gaussian [1 2 1; 2 4 2; 1 2 1]/16 filter with a 3-stage pipeline.
// Define OUT_COORD_EN to add the out_col centre-column output.
module conv3x3_gauss
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LENGTH     = 100,
  parameter int unsigned COL_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] row_top,
  input  logic [DATA_WIDTH-1:0] row_mid,
  input  logic [DATA_WIDTH-1:0] row_bot,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid
`ifdef OUT_COORD_EN
  ,
  output logic [COL_WIDTH-1:0]  out_col
`endif
);

  localparam int unsigned RS_WIDTH  = DATA_WIDTH + 2;
  localparam int unsigned SUM_WIDTH = sum_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] row_in [3];
  logic [DATA_WIDTH-1:0] w_q    [3][3];
  logic [COL_WIDTH-1:0]  col_q, col_d;
  logic                  win_vld_q;
  logic [RS_WIDTH-1:0]   rs_d   [3];
  logic [RS_WIDTH-1:0]   rs_q   [3];
  logic                  vld2_q;
  logic [SUM_WIDTH-1:0]  sum_d;
  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
  logic                  out_valid_q;

  always_comb begin
    row_in[0] = row_top;
    row_in[1] = row_mid;
    row_in[2] = row_bot;
    col_d     = (col_q == COL_WIDTH'(LENGTH - 1)) ? '0 : col_q + 1'b1;
  end

  // Stage 1: column counter and sliding window. Columns 0 and 1 of a line
  // only fill the window, so stale pixels never reach a valid output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q     <= '0;
      win_vld_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int t = 0; t < 3; t++) begin
          w_q[r][t] <= '0;
        end
      end
    end else begin
      win_vld_q <= in_valid && (col_q >= COL_WIDTH'(2));
      if (in_valid) begin
        col_q <= col_d;
        for (int r = 0; r < 3; r++) begin
          w_q[r][2] <= w_q[r][1];
          w_q[r][1] <= w_q[r][0];
          w_q[r][0] <= row_in[r];
        end
      end
    end
  end

  // Stage 2: horizontal 1-2-1 per kernel row.
  for (genvar r = 0; r < 3; r++) begin : g_row
    row_sum121 #(
      .IN_WIDTH  (DATA_WIDTH),
      .OUT_WIDTH (RS_WIDTH)
    ) u_row_sum (
      .px_0 (w_q[r][0]),
      .px_1 (w_q[r][1]),
      .px_2 (w_q[r][2]),
      .sum  (rs_d[r])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld2_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        rs_q[r] <= '0;
      end
    end else begin
      vld2_q <= win_vld_q;
      for (int r = 0; r < 3; r++) begin
        rs_q[r] <= rs_d[r];
      end
    end
  end

  // Stage 3: vertical 1-2-1 across row sums, then round-half-up divide by 16.
  row_sum121 #(
    .IN_WIDTH  (RS_WIDTH),
    .OUT_WIDTH (SUM_WIDTH)
  ) u_col_sum (
    .px_0 (rs_q[0]),
    .px_1 (rs_q[1]),
    .px_2 (rs_q[2]),
    .sum  (sum_d)
  );

  always_comb begin
    data_out_d = DATA_WIDTH'((sum_d + SUM_WIDTH'(ROUND)) >> KSHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld2_q;
      if (vld2_q) begin
        data_out_q <= data_out_d;
      end
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

`ifdef OUT_COORD_EN
  logic [COL_WIDTH-1:0] ctr1_q, ctr2_q, out_col_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr1_q    <= '0;
      ctr2_q    <= '0;
      out_col_q <= '0;
    end else begin
      if (in_valid) begin
        ctr1_q <= col_q - 1'b1;
      end
      ctr2_q <= ctr1_q;
      if (vld2_q) begin
        out_col_q <= ctr2_q;
      end
    end
  end

  assign out_col = out_col_q;
`endif

endmodule

// File: tb/tb_conv3x3_gauss.sv
// Self-checking bench for conv3x3_gauss: table of single-line patterns with a
// scoreboard for values and latency, plus a mid-line reset sequence.
module tb_conv3x3_gauss;

  localparam int unsigned DW  = 16;
  localparam int unsigned LEN = 100;
  localparam int unsigned CW  = 7;
  localparam int          NV  = 10;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] row_top, row_mid, row_bot;
  logic          in_valid;
  logic [DW-1:0] data_out;
  logic          out_valid;
`ifdef OUT_COORD_EN
  logic [CW-1:0] out_col;
`endif

  conv3x3_gauss #(
    .DATA_WIDTH (DW),
    .LENGTH     (LEN),
    .COL_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_top   (row_top),
    .row_mid   (row_mid),
    .row_bot   (row_bot),
    .in_valid  (in_valid),
    .data_out  (data_out),
    .out_valid (out_valid)
`ifdef OUT_COORD_EN
    ,
    .out_col   (out_col)
`endif
  );

  // imp_row: 0 top, 1 mid, 2 bot, 3 none. Expected values are for the
  // centre column equal to imp_col (ctr), one away (side), and elsewhere.
  typedef struct {
    int fill;
    int imp_row;
    int imp_col;
    int imp_val;
    int exp_fill;
    int exp_side;
    int exp_ctr;
    bit gaps;
  } vec_t;

  typedef struct {
    int k;
    int exp;
    int vi;
  } ent_t;

  vec_t          vecs [NV];
  ent_t          expq [$];
  int            got  [NV];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  bit            mon_en   = 1'b0;
  logic [DW-1:0] last_out = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int pix(input int v, input int row, input int c);
    if (vecs[v].imp_row == row && vecs[v].imp_col == c) return vecs[v].imp_val;
    return vecs[v].fill;
  endfunction

  function automatic int exp_at(input int v, input int x);
    int d;
    if (vecs[v].imp_row == 3) return vecs[v].exp_fill;
    d = x - vecs[v].imp_col;
    if (d < 0) d = -d;
    if (d == 0) return vecs[v].exp_ctr;
    if (d == 1) return vecs[v].exp_side;
    return vecs[v].exp_fill;
  endfunction

  // Drives columns 0..stop_col-1; inputs are sampled at the edge after cyc+1.
  task automatic drive_line(input int v, input int stop_col);
    for (int c = 0; c < LEN; c++) begin
      if (c == stop_col) return;
      if (vecs[v].gaps) begin
        int n;
        n = $urandom_range(0, 3);
        in_valid = 1'b0;
        repeat (n) begin
          @(posedge clk);
          #1;
        end
      end
      row_top  = DW'(pix(v, 0, c));
      row_mid  = DW'(pix(v, 1, c));
      row_bot  = DW'(pix(v, 2, c));
      in_valid = 1'b1;
      if (c >= 2) expq.push_back('{k: cyc + 1, exp: exp_at(v, c - 1), vi: v});
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        ent_t e;
        if (expq.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          check("data_out", int'(data_out), e.exp);
          check("latency", cyc, e.k + 2);
          got[e.vi]++;
        end
        last_out = data_out;
      end else begin
        check("hold_data_out", int'(data_out), int'(last_out));
      end
    end
  end

  initial begin
    vecs[0] = '{fill: 100,   imp_row: 3, imp_col: 0,  imp_val: 0,  exp_fill: 100,
                exp_side: 100,   exp_ctr: 100,   gaps: 1'b0};
    vecs[1] = '{fill: 0,     imp_row: 1, imp_col: 5,  imp_val: 16, exp_fill: 0,
                exp_side: 2,     exp_ctr: 4,     gaps: 1'b0};
    vecs[2] = '{fill: 0,     imp_row: 0, imp_col: 5,  imp_val: 8,  exp_fill: 0,
                exp_side: 1,     exp_ctr: 1,     gaps: 1'b0};
    vecs[3] = '{fill: 65535, imp_row: 3, imp_col: 0,  imp_val: 0,  exp_fill: 65535,
                exp_side: 65535, exp_ctr: 65535, gaps: 1'b0};
    vecs[4] = '{fill: 0,     imp_row: 1, imp_col: 5,  imp_val: 16, exp_fill: 0,
                exp_side: 2,     exp_ctr: 4,     gaps: 1'b1};
    vecs[5] = '{fill: 0,     imp_row: 2, imp_col: 1,  imp_val: 32, exp_fill: 0,
                exp_side: 2,     exp_ctr: 4,     gaps: 1'b0};
    vecs[6] = '{fill: 0,     imp_row: 1, imp_col: 98, imp_val: 16, exp_fill: 0,
                exp_side: 2,     exp_ctr: 4,     gaps: 1'b0};
    vecs[7] = '{fill: 5,     imp_row: 0, imp_col: 50, imp_val: 21, exp_fill: 5,
                exp_side: 6,     exp_ctr: 7,     gaps: 1'b0};
    vecs[8] = '{fill: 50,    imp_row: 3, imp_col: 0,  imp_val: 0,  exp_fill: 50,
                exp_side: 50,    exp_ctr: 50,    gaps: 1'b0};
    vecs[9] = '{fill: 7,     imp_row: 3, imp_col: 0,  imp_val: 0,  exp_fill: 7,
                exp_side: 7,     exp_ctr: 7,     gaps: 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    row_top  = '0;
    row_mid  = '0;
    row_bot  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_data_out", int'(data_out), 0);
`ifdef OUT_COORD_EN
    check("reset_out_col", int'(out_col), 0);
`endif
    last_out = '0;
    mon_en   = 1'b1;
    rst_n    = 1'b1;

    // Lines run back to back with no idle cycles between them.
    for (int v = 0; v < 8; v++) drive_line(v, LEN);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int v = 0; v < 8; v++) check($sformatf("line%0d_count", v), got[v], LEN - 2);

    // Reset in the middle of a line: outputs still in the pipeline are lost.
    drive_line(8, 50);
    rst_n = 1'b0;
    while (expq.size() > 0 && expq[$].k >= cyc - 1) void'(expq.pop_back());
    repeat (2) begin
      @(posedge clk);
      #1;
      last_out = '0;
      in_valid = 1'b0;
      check("midreset_out_valid", int'(out_valid), 0);
      check("midreset_data_out", int'(data_out), 0);
    end
    rst_n = 1'b1;
    drive_line(9, LEN);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_count", got[9], LEN - 2);
    check("scoreboard_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
